// File: rtl/fp_mult_mant_core.sv
// FP multiplier mantissa stage: iterative shift-add fraction product, biased exponent sum,
// special-value resolution. Define FP_MULT_RADIX4_EN for 2 multiplier bits per cycle.
module fp_mult_mant_core #(
  parameter int EXP_LEN  = 8,
  parameter int MANT_LEN = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXP_LEN-1:0]         in_a_exp,
  input  logic [EXP_LEN-1:0]         in_b_exp,
  input  logic [MANT_LEN:0]          in_a_frac,
  input  logic [MANT_LEN:0]          in_b_frac,
  input  logic                       in_a_zero,
  input  logic                       in_b_zero,
  input  logic                       in_a_inf,
  input  logic                       in_b_inf,
  input  logic                       in_a_nan,
  input  logic                       in_b_nan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [EXP_LEN+1:0]         out_exp,
  output logic [2*MANT_LEN+1:0]      out_prod,
  output logic                       out_zero,
  output logic                       out_inf,
  output logic                       out_nan
);
  localparam int F    = MANT_LEN + 1;
  localparam int P    = 2 * F;
  localparam int XW   = EXP_LEN + 2;
  localparam int BIAS = (1 << (EXP_LEN - 1)) - 1;
`ifdef FP_MULT_RADIX4_EN
  localparam int N  = (F + 1) / 2;
  localparam int BW = 2 * N;
`else
  localparam int N  = F;
  localparam int BW = F;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [P-1:0]    acc_r;
  logic [F-1:0]    a_r;
  logic [BW-1:0]   b_r;
  logic [XW-1:0]   exp_base_r;
  logic            out_sign_r, out_zero_r, out_inf_r, out_nan_r;
  logic [XW-1:0]   out_exp_r;
  logic [P-1:0]    out_prod_r;
`ifdef FP_MULT_RADIX4_EN
  logic [F+1:0]    a3_r;
`endif

  logic            accept_s, nan_s, inf_s, zero_s, special_s, last_s;
  logic [BW-1:0]   b_ext_s;
  logic [XW-1:0]   exp_sum_s;
  logic [P-1:0]    mult_s, addend_s, acc_next_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_sign  = out_sign_r;
  assign out_exp   = out_exp_r;
  assign out_prod  = out_prod_r;
  assign out_zero  = out_zero_r;
  assign out_inf   = out_inf_r;
  assign out_nan   = out_nan_r;

  // Accept decode, special-value resolution and exponent sum
  always_comb begin
    accept_s   = in_valid && (state_r == IDLE);
    nan_s      = in_a_nan | in_b_nan | (in_a_zero & in_b_inf) | (in_a_inf & in_b_zero);
    inf_s      = (in_a_inf | in_b_inf) & ~nan_s;
    zero_s     = (in_a_zero | in_b_zero) & ~nan_s & ~inf_s;
    special_s  = nan_s | inf_s | zero_s;
    b_ext_s    = '0;
    b_ext_s[F-1:0] = in_b_frac;
    exp_sum_s  = XW'(in_a_exp) + XW'(in_b_exp) - XW'(BIAS);
  end

  // One shift-add step of the multiplier
  always_comb begin
    mult_s = '0;
`ifdef FP_MULT_RADIX4_EN
    case (b_r[{cnt_r, 1'b0} +: 2])
      2'd0:    mult_s = '0;
      2'd1:    mult_s = P'(a_r);
      2'd2:    mult_s = P'({a_r, 1'b0});
      2'd3:    mult_s = P'(a3_r);
      default: mult_s = '0;
    endcase
    addend_s = mult_s << {cnt_r, 1'b0};
`else
    if (b_r[cnt_r]) begin
      mult_s = P'(a_r);
    end else begin
      mult_s = '0;
    end
    addend_s = mult_s << cnt_r;
`endif
    acc_next_s = acc_r + addend_s;
    last_s     = (cnt_r == CW'(N - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = MUL;
        else          state_next_s = IDLE;
      end
      MUL: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = MUL;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, accumulation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      acc_r      <= '0;
      a_r        <= '0;
      b_r        <= '0;
      exp_base_r <= '0;
      out_sign_r <= 1'b0;
      out_zero_r <= 1'b0;
      out_inf_r  <= 1'b0;
      out_nan_r  <= 1'b0;
      out_exp_r  <= '0;
      out_prod_r <= '0;
`ifdef FP_MULT_RADIX4_EN
      a3_r       <= '0;
`endif
    end else if (accept_s) begin
      // Specials run a single all-zero step so their result lands one cycle after accept
      acc_r      <= '0;
      cnt_r      <= special_s ? CW'(N - 1) : '0;
      a_r        <= in_a_frac;
      b_r        <= special_s ? '0 : b_ext_s;
      exp_base_r <= special_s ? '0 : exp_sum_s;
      out_sign_r <= in_sign;
      out_zero_r <= zero_s;
      out_inf_r  <= inf_s;
      out_nan_r  <= nan_s;
`ifdef FP_MULT_RADIX4_EN
      a3_r       <= {2'b00, in_a_frac} + {1'b0, in_a_frac, 1'b0};
`endif
    end else if (state_r == MUL) begin
      acc_r <= acc_next_s;
      cnt_r <= cnt_r + CW'(1);
      if (last_s) begin
        out_prod_r <= acc_next_s;
        out_exp_r  <= exp_base_r + XW'(acc_next_s[P-1]);
      end
    end
  end
endmodule

// File: tb/tb_fp_mult_mant_core.sv
// Scoreboard bench for fp_mult_mant_core (FP32): directed vectors, queue-based monitor.
module tb_fp_mult_mant_core;
`ifdef FP_MULT_RADIX4_EN
  localparam int N = 12;
`else
  localparam int N = 24;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sign, out_valid, out_ready, out_sign;
  logic [7:0]  in_a_exp, in_b_exp;
  logic [23:0] in_a_frac, in_b_frac;
  logic        in_a_zero, in_b_zero, in_a_inf, in_b_inf, in_a_nan, in_b_nan;
  logic [9:0]  out_exp;
  logic [47:0] out_prod;
  logic        out_zero, out_inf, out_nan;

  always #5 clk = ~clk;

  fp_mult_mant_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_a_exp(in_a_exp), .in_b_exp(in_b_exp), .in_a_frac(in_a_frac), .in_b_frac(in_b_frac),
    .in_a_zero(in_a_zero), .in_b_zero(in_b_zero), .in_a_inf(in_a_inf), .in_b_inf(in_b_inf),
    .in_a_nan(in_a_nan), .in_b_nan(in_b_nan), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_prod(out_prod), .out_zero(out_zero),
    .out_inf(out_inf), .out_nan(out_nan)
  );

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] prod;
    logic        zero;
    logic        inf;
    logic        nan;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   valid_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_cyc = cyc;
  end

  // Monitor: latency on first valid cycle, full compare on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: out_valid=1 with empty scoreboard, prod %0h", out_prod);
      end else begin
        if (!valid_seen) begin
          check("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
          valid_seen = 1'b1;
        end
        if (out_ready) begin
          mon_e = sb.pop_front();
          check("sign", 64'(out_sign), 64'(mon_e.sign));
          check("exp",  64'(out_exp),  64'(mon_e.exp));
          check("prod", 64'(out_prod), 64'(mon_e.prod));
          check("flags", 64'({out_zero, out_inf, out_nan}), 64'({mon_e.zero, mon_e.inf, mon_e.nan}));
          valid_seen = 1'b0;
        end
      end
    end
  end

  // fl = {a_zero, b_zero, a_inf, b_inf, a_nan, b_nan}
  task automatic issue(input logic s, input logic [7:0] ae, input logic [7:0] be,
                       input logic [23:0] af, input logic [23:0] bf, input logic [5:0] fl,
                       input logic [47:0] prod, input logic [9:0] ex,
                       input logic ez, input logic ei, input logic en);
    exp_t e;
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
    end
    in_valid = 1'b1; in_sign = s; in_a_exp = ae; in_b_exp = be; in_a_frac = af; in_b_frac = bf;
    {in_a_zero, in_b_zero, in_a_inf, in_b_inf, in_a_nan, in_b_nan} = fl;
    e.sign = s; e.exp = ex; e.prod = prod; e.zero = ez; e.inf = ei; e.nan = en;
    e.lat = (ez | ei | en) ? 8'd1 : 8'(N);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sign = 1'b1; in_a_exp = 8'hA5; in_b_exp = 8'h5A;
    in_a_frac = 24'h5A5A5A; in_b_frac = 24'hA5A5A5;
    {in_a_zero, in_b_zero, in_a_inf, in_b_inf, in_a_nan, in_b_nan} = 6'b111111;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sign = 1'b0;
    in_a_exp = 8'd0; in_b_exp = 8'd0; in_a_frac = 24'd0; in_b_frac = 24'd0;
    {in_a_zero, in_b_zero, in_a_inf, in_b_inf, in_a_nan, in_b_nan} = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", 64'(out_prod), 64'd0);
    check("rst_out_exp", 64'(out_exp), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal products
    issue(1'b0, 8'd127, 8'd128, 24'hC00000, 24'h800000, 6'b000000, 48'h600000000000, 10'd128, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 8'd127, 8'd127, 24'hC00000, 24'hC00000, 6'b000000, 48'h900000000000, 10'd128, 1'b0, 1'b0, 1'b0);
    // Specials
    issue(1'b0, 8'd0,   8'd255, 24'h000000, 24'h800000, 6'b100100, 48'h0, 10'd0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 8'd0,   8'd130, 24'h000000, 24'hA00000, 6'b100000, 48'h0, 10'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 8'd255, 8'd100, 24'h800000, 24'hC00000, 6'b001000, 48'h0, 10'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 8'd255, 8'd100, 24'hC00000, 24'hC00000, 6'b000010, 48'h0, 10'd0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Backpressure: 1.25*1.25, exps 130/125
    out_ready = 1'b0;
    issue(1'b0, 8'd130, 8'd125, 24'hA00000, 24'hA00000, 6'b000000, 48'h640000000000, 10'd128, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 100 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_prod", 64'(out_prod), 64'h640000000000);
      check("stall_exp", 64'(out_exp), 64'd128);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a multiply
    issue(1'b0, 8'd127, 8'd128, 24'hC00000, 24'h800000, 6'b000000, 48'h600000000000, 10'd128, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_prod", 64'(out_prod), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    issue(1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 6'b000000, 48'h400000000000, 10'd127, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Exponent extremes and largest fraction product
    issue(1'b0, 8'd1,   8'd1,   24'h800000, 24'h800000, 6'b000000, 48'h400000000000, 10'h383, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 8'd254, 8'd254, 24'h800000, 24'h800000, 6'b000000, 48'h400000000000, 10'd381, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 8'd254, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 6'b000000, 48'hFFFFFE000001, 10'd382, 1'b0, 1'b0, 1'b0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
